// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and read-slave FSM state encoding.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } rd_state_e;

endpackage

// File: rtl/axi4_lite_addr_fifo.sv
// Ordered queue of accepted read addresses; head is the oldest entry.
// Latency: a push is visible at head the cycle after the write edge when empty.
// Backpressure: full is registered state; push when full and pop when empty are dropped.
module axi4_lite_addr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/axi4_lite_read_slave_q.sv
// AXI4-Lite read slave with an address queue, window decode and a timed backend handshake.
// Latency: queued head issues mem_req next cycle; backend data gives RVALID one cycle later.
// Backpressure: ARREADY drops when the queue is full; RVALID holds registered data until RREADY.
module axi4_lite_read_slave_q
   import axi4_lite_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter int          DEPTH      = 4,
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] ADDR_SPAN  = 32'h0000_1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rvalid,
   output logic [15:0]           err_count
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // One extra bit keeps BASE_ADDR+ADDR_SPAN from wrapping at the top of the map.
   localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(ADDR_SPAN);

   rd_state_e             state;
   rd_state_e             nstate;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [ADDR_WIDTH-1:0] fifo_head;
   logic                  head_in_range;
   logic                  push;
   logic                  pop;
   logic [CW-1:0]         wait_cnt;
   logic                  timeout_hit;
   logic [DATA_WIDTH-1:0] rdata_q;
   axi_resp_e             rresp_q;

   assign push          = S_AXI_ARVALID && S_AXI_ARREADY;
   assign pop           = (state == RESP) && S_AXI_RREADY;
   assign head_in_range = ({1'b0, fifo_head} >= WIN_LO) && ({1'b0, fifo_head} < WIN_HI);
   assign timeout_hit   = (wait_cnt == CW'(TIMEOUT - 1));
   assign mem_addr      = fifo_empty ? '0 : fifo_head - ADDR_WIDTH'(BASE_ADDR);

   axi4_lite_addr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_addr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (S_AXI_ARADDR),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (!fifo_empty) nstate = head_in_range ? WAIT : RESP;
         WAIT:    if (mem_rvalid || timeout_hit) nstate = RESP;
         RESP:    if (S_AXI_RREADY) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // ARREADY also falls with rst itself so it is low during reset and up right after.
   always_comb begin
      mem_req       = (state == IDLE) && !fifo_empty && head_in_range;
      S_AXI_ARREADY = !rst && !fifo_full;
      S_AXI_RVALID  = (state == RESP);
      S_AXI_RDATA   = S_AXI_RVALID ? rdata_q : '0;
      S_AXI_RRESP   = S_AXI_RVALID ? rresp_q : OKAY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt  <= '0;
         rdata_q   <= '0;
         rresp_q   <= OKAY;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (!fifo_empty && !head_in_range) begin
                  rdata_q <= '0;
                  rresp_q <= DECERR;
               end
            end
            // Backend data wins over a timeout landing in the same cycle.
            WAIT: begin
               if (mem_rvalid) begin
                  rdata_q <= mem_rdata;
                  rresp_q <= OKAY;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
                  if (timeout_hit) begin
                     rdata_q <= '0;
                     rresp_q <= SLVERR;
                  end
               end
            end
            default: ;
         endcase
         if (pop && (rresp_q == SLVERR || rresp_q == DECERR) && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_axi4_lite_read_slave_q.sv
// Randomized bench: a queue-of-requests reference model predicts every handshake,
// backend strobe, response value/timing and error count cycle by cycle.
module tb_axi4_lite_read_slave_q;

   localparam int          DEPTH   = 4;
   localparam int          TIMEOUT = 8;
   localparam logic [31:0] BASE    = 32'h0000_0000;
   localparam logic [31:0] SPAN    = 32'h0000_1000;
   localparam int          NEVER   = 2147483647;

   logic        clk;
   logic        rst;
   logic [31:0] S_AXI_ARADDR;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic [15:0] err_count;

   axi4_lite_read_slave_q #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (DEPTH),
      .TIMEOUT    (TIMEOUT),
      .BASE_ADDR  (BASE),
      .ADDR_SPAN  (SPAN)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .err_count     (err_count)
   );

   typedef struct {
      logic [31:0] addr;
      bit          inr;
      bit          issued;
      int          head_cyc;
      int          iss_cyc;
      int          exp_rv;
      logic [1:0]  resp;
      logic [31:0] data;
   } req_t;

   req_t        q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          model_err = 0;
   bit          pend_vld = 0;
   int          pend_cyc = 0;
   logic [31:0] pend_dat = '0;
   bit          arv_hold = 0;
   logic [31:0] ar_addr = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(SPAN));
   endfunction

   function automatic logic [31:0] pick_addr(input int p_out);
      logic [31:0] a;
      if ($urandom_range(0, 99) < p_out) begin
         case ($urandom_range(0, 3))
            0:       a = 32'h0000_1000;
            1:       a = 32'h0000_2000;
            2:       a = 32'hFFFF_FFFC;
            default: a = $urandom | 32'h0000_1000;
         endcase
      end else begin
         case ($urandom_range(0, 9))
            0:       a = 32'h0000_0FFC;
            1:       a = 32'h0000_0010;
            default: a = 32'($urandom_range(0, 1023)) << 2;
         endcase
      end
      return a;
   endfunction

   task automatic step(input int p_ar, input int p_rr, input int p_out, output bit in_wait);
      req_t        r;
      bit          exp_mreq, exp_rv, drv, rr, pop, push;
      logic [31:0] drv_dat;
      int          j, k;
      @(negedge clk);
      drv     = pend_vld && (pend_cyc == cyc);
      drv_dat = pend_dat;
      if (drv || (pend_vld && pend_cyc < cyc)) pend_vld = 0;

      exp_mreq = (q.size() > 0) && q[0].inr && !q[0].issued && (cyc == q[0].head_cyc + 1);
      check("mem_req", mem_req, exp_mreq);
      if (mem_req && q.size() > 0 && q[0].inr && !q[0].issued) begin
         r = q[0];
         check("mem_addr", mem_addr, r.addr - BASE);
         k = $urandom_range(0, 9);
         if (k < 3)      j = TIMEOUT;
         else if (k < 5) j = TIMEOUT + $urandom_range(1, 2);
         else            j = $urandom_range(1, TIMEOUT - 1);
         pend_vld  = 1;
         pend_cyc  = cyc + j;
         pend_dat  = $urandom;
         r.issued  = 1;
         r.iss_cyc = cyc;
         if (j <= TIMEOUT) begin
            r.resp = 2'b00; r.data = pend_dat; r.exp_rv = cyc + j + 1;
         end else begin
            r.resp = 2'b10; r.data = '0;       r.exp_rv = cyc + TIMEOUT + 1;
         end
         q[0] = r;
      end

      exp_rv = (q.size() > 0) && (cyc >= q[0].exp_rv);
      check("rvalid", S_AXI_RVALID, exp_rv);
      if (exp_rv) begin
         check("rdata", S_AXI_RDATA, q[0].data);
         check("rresp", S_AXI_RRESP, q[0].resp);
      end else begin
         check("rdata_idle", S_AXI_RDATA, 0);
         check("rresp_idle", S_AXI_RRESP, 0);
      end
      check("arready", S_AXI_ARREADY, q.size() < DEPTH);
      check("err_count", err_count, model_err);
      in_wait = (q.size() > 0) && q[0].issued && (cyc > q[0].iss_cyc) && (cyc < q[0].exp_rv);

      rr   = ($urandom_range(0, 99) < p_rr);
      pop  = exp_rv && rr;
      if (!arv_hold && $urandom_range(0, 99) < p_ar) begin
         arv_hold = 1;
         ar_addr  = pick_addr(p_out);
      end
      push = arv_hold && (q.size() < DEPTH);

      S_AXI_ARVALID = arv_hold;
      S_AXI_ARADDR  = arv_hold ? ar_addr : $urandom;
      S_AXI_RREADY  = rr;
      mem_rvalid    = drv;
      mem_rdata     = drv ? drv_dat : $urandom;

      if (pop) begin
         if (q[0].resp != 2'b00 && model_err < 16'hFFFF) model_err++;
         void'(q.pop_front());
         if (q.size() > 0) begin
            r = q[0];
            r.head_cyc = cyc;
            r.exp_rv   = r.inr ? NEVER : cyc + 2;
            q[0] = r;
         end
      end
      if (push) begin
         r.addr     = ar_addr;
         r.inr      = in_win(ar_addr);
         r.issued   = 0;
         r.iss_cyc  = 0;
         r.resp     = 2'b11;
         r.data     = '0;
         r.head_cyc = (q.size() == 0) ? cyc : -100;
         r.exp_rv   = (q.size() == 0 && !r.inr) ? cyc + 2 : NEVER;
         q.push_back(r);
         arv_hold = 0;
      end
   endtask

   task automatic run(input int n, input int p_ar, input int p_rr, input int p_out);
      bit w;
      for (int i = 0; i < n; i++) step(p_ar, p_rr, p_out, w);
   endtask

   task automatic apply_reset();
      rst           = 1'b1;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      mem_rvalid    = 1'b0;
      #1;
      check("rst_arready", S_AXI_ARREADY, 0);
      check("rst_rvalid", S_AXI_RVALID, 0);
      check("rst_rdata", S_AXI_RDATA, 0);
      check("rst_rresp", S_AXI_RRESP, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_err_count", err_count, 0);
      q.delete();
      model_err = 0;
      arv_hold  = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arready_after_rst", S_AXI_ARREADY, 1);
      // A stale backend answer right after reset must be ignored.
      pend_vld = 1;
      pend_cyc = cyc + 1;
      pend_dat = $urandom;
   endtask

   initial begin
      bit found;
      rst           = 1'b0;
      S_AXI_ARADDR  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      mem_rdata     = '0;
      mem_rvalid    = 1'b0;
      #1;
      apply_reset();

      run(300, 40, 70, 25);
      run(30, 100, 0, 0);
      run(300, 50, 50, 20);

      found = 0;
      for (int i = 0; i < 200 && !found; i++) step(60, 70, 0, found);
      check("reach_wait", found, 1);
      apply_reset();
      run(15, 0, 100, 0);

      run(300, 40, 80, 20);
      run(60, 0, 100, 0);
      check("drained", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi4_lite_read_slave_q.md
AXI4_LITE_READ_SLAVE_Q -- requirements
Module: axi4_lite_read_slave_q

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, data width.
REQ-003 SHALL have parameter DEPTH, 4, outstanding read-address queue entries; power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, 255, maximum backend wait cycles; at least 1.
REQ-005 SHALL have parameter BASE_ADDR, 32'h0000_0000, first decoded byte address.
REQ-006 SHALL have parameter ADDR_SPAN, 32'h0000_1000, decoded window size in bytes.
REQ-007 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-009 SHALL have port S_AXI_ARADDR  input  ADDR_WIDTH  read address.
REQ-010 SHALL have port S_AXI_ARVALID  input  1  address valid.
REQ-011 SHALL have port S_AXI_ARREADY  output  1  address accepted.
REQ-012 SHALL have port S_AXI_RDATA  output  DATA_WIDTH  read data.
REQ-013 SHALL have port S_AXI_RRESP  output  2  response code.
REQ-014 SHALL have port S_AXI_RVALID  output  1  response valid.
REQ-015 SHALL have port S_AXI_RREADY  input  1  master ready.
REQ-016 SHALL have port mem_req  output  1  one-cycle backend read strobe.
REQ-017 SHALL have port mem_addr  output  ADDR_WIDTH  backend address, equal to the queue-head address minus BASE_ADDR.
REQ-018 SHALL have port mem_rdata  input  DATA_WIDTH  backend data.
REQ-019 SHALL have port mem_rvalid  input  1  backend data valid.
REQ-020 SHALL have port err_count  output  16  saturating count of non-OKAY responses.

Function
REQ-021 SHALL drive S_AXI_ARREADY = not queue-full, derived from registered state only and not from ARVALID.
REQ-022 SHALL push ARADDR into the queue on the edge where ARVALID and ARREADY are both high; the queue preserves order.
REQ-023 SHALL decode an address as in range when BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN, with the comparison done at ADDR_WIDTH+1 bits so the upper bound does not wrap.
REQ-024 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-025 IDLE: with the queue non-empty and the head in range, SHALL assert mem_req for that cycle, clear the wait counter and go to WAIT.
REQ-026 IDLE: with the head out of range, SHALL issue no mem_req, load RDATA=0 and RRESP=DECERR (2'b11), and go to RESP.
REQ-027 WAIT: on mem_rvalid, SHALL capture mem_rdata into the data register, set RRESP=OKAY (2'b00) and go to RESP.
REQ-028 WAIT: with no mem_rvalid, SHALL increment the counter; once TIMEOUT wait cycles have elapsed, SHALL load RDATA=0 and RRESP=SLVERR (2'b10) and go to RESP.
REQ-029 SHALL give mem_rvalid priority when it coincides with the timeout cycle, producing OKAY.
REQ-030 SHALL ignore mem_rvalid outside WAIT.
REQ-031 RESP: SHALL hold RVALID=1 with RDATA and RRESP driven from registers, stable until RREADY.
REQ-032 RESP: on RVALID and RREADY, SHALL pop the queue and return to IDLE; the next request issues one cycle later at the earliest.
REQ-033 SHALL meet this latency: handshake at edge k gives mem_req in cycle k+1 when the queue was empty; mem_rvalid in cycle m gives RVALID from cycle m+1.
REQ-034 SHALL handle simultaneous push and pop in the same cycle with the count unchanged.
REQ-035 SHALL wrap queue pointers modulo DEPTH.
REQ-036 SHALL increment err_count on every popped SLVERR or DECERR response, saturating at 16'hFFFF.
REQ-037 SHALL drive RDATA=0 and RRESP=0 whenever RVALID=0.

Reset
REQ-038 SHALL, on rst, enter IDLE, empty the queue and discard any in-flight request without a response.
REQ-039 SHALL, on rst, drive ARREADY=0, RVALID=0, RDATA=0, RRESP=0, mem_req=0, mem_addr=0 and err_count=0.
REQ-040 SHALL raise ARREADY in the first cycle after rst deasserts.
REQ-041 SHALL ignore a mem_rvalid arriving after a reset in mid-WAIT.

Structure
REQ-042 SHALL place the response-code enum (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state enum in shared package axi4_lite_pkg.
REQ-043 SHALL implement the queue as sub-module axi4_lite_addr_fifo, with parameters DEPTH and WIDTH and outputs full, empty and head.

Verification
REQ-044 Single read: ARADDR=0x10, backend returns 0xDEADBEEF after 3 cycles -> mem_req once, mem_addr=0x10, RDATA=0xDEADBEEF, RRESP=00.
REQ-045 Decode error: ARADDR=0x2000 with the default window -> no mem_req, RRESP=11, RDATA=0, err_count=1.
REQ-046 Timeout: TIMEOUT=8, backend never answers -> RRESP=10 exactly 8 WAIT cycles after mem_req; a late mem_rvalid is ignored.
REQ-047 Backpressure and queue: 5 back-to-back ARs with DEPTH=4 and RREADY=0 -> ARREADY falls after 4 accepts; responses come in order, and RDATA is stable while stalled.
REQ-048 Coincidence: mem_rvalid arrives on the timeout cycle -> RRESP=00 with the backend data.
REQ-049 Reset mid-WAIT: assert rst -> all outputs 0, no response, and the next read completes normally.
